// File: rtl/mc_controller.sv
// ============================================================================
// mc_controller
// ----------------------------------------------------------------------------
// Control FSM for the multicycle MIPS datapath. It steps each instruction
// through fetch, decode, execute, memory and writeback. It also drives the
// datapath enables, mux selects and ALU control.
//
// Memory accesses (FETCH, MEMRD, MEMWR) use a ready handshake. A wait counter
// flags mem_timeout and parks the FSM in HALT when TIMEOUT_CYCLES consecutive
// wait cycles elapse. Setting TIMEOUT_CYCLES to 0 disables the timeout.
//
// Optional feature macro:
//   CTRL_BNE_EN - when defined, bne (op 000101) is decoded as a branch taken
//                 on ~zero. When undefined, op 000101 is an illegal opcode.
//
// Parameters:
//   TIMEOUT_CYCLES - consecutive wait cycles before a fault (0 = never)
//   CNT_W          - wait counter width, TIMEOUT_CYCLES < 2**CNT_W
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous active-low reset
//   op, funct    in   instruction fields from the instruction register
//   zero         in   ALU zero flag
//   mem_ready    in   memory completes the current access this cycle
//   mem_req      out  memory access request
//   memwrite     out  memory write strobe
//   pcen         out  PC write enable
//   irwrite      out  instruction register load
//   regwrite     out  register file write
//   alusrca      out  ALU A select (0 pc, 1 A)
//   iord         out  address select (0 pc, 1 aluout)
//   memtoreg     out  writeback select (0 aluout, 1 memory data)
//   regdst       out  destination select (0 rt, 1 rd)
//   alusrcb      out  ALU B select (00 B, 01 4, 10 imm, 11 imm<<2)
//   pcsrc        out  next PC select (00 aluresult, 01 aluout, 10 jump)
//   alucontrol   out  ALU operation
//   illegal_op   out  one-cycle pulse on an unsupported opcode in DECODE
//   mem_timeout  out  sticky wait-state timeout fault
//   state        out  current state encoding (debug)
// ============================================================================
module mc_controller #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       memwrite,
    output logic       pcen,
    output logic       irwrite,
    output logic       regwrite,
    output logic       alusrca,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       illegal_op,
    output logic       mem_timeout,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_IMMWB  = 4'd10,
        S_JUMP   = 4'd11,
        S_ORIEX  = 4'd12,
        S_HALT   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [CNT_W-1:0] TIMEOUT_L = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    // R-type funct field to ALU operation; unknown functs fall back to add
    function automatic logic [2:0] alu_from_funct(input logic [5:0] f);
        logic [2:0] res;
        case (f)
            6'b100000: res = ALU_ADD;
            6'b100010: res = ALU_SUB;
            6'b100100: res = ALU_AND;
            6'b100101: res = ALU_OR;
            6'b101010: res = ALU_SLT;
            default:   res = ALU_ADD;
        endcase
        return res;
    endfunction

    state_t           state_r;
    state_t           next_state_s;
    logic [CNT_W-1:0] wait_cnt_r;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             mem_timeout_r;
    logic             wait_s;
    logic             timeout_hit_s;
    logic             branch_taken_s;
    logic             illegal_s;

    // Raw (ungated) decoded outputs of the current state
    logic       mem_req_s;
    logic       memwrite_s;
    logic       pcen_s;
    logic       irwrite_s;
    logic       regwrite_s;
    logic       alusrca_s;
    logic       iord_s;
    logic       memtoreg_s;
    logic       regdst_s;
    logic [1:0] alusrcb_s;
    logic [1:0] pcsrc_s;
    logic [2:0] alucontrol_s;

    // Branch condition: beq uses zero, bne (when enabled) its inverse.
    // op stays valid here because the instruction register only loads in FETCH.
    always_comb begin
`ifdef CTRL_BNE_EN
        if (op == OP_BNE) begin
            branch_taken_s = ~zero;
        end else begin
            branch_taken_s = zero;
        end
`else
        branch_taken_s = zero;
`endif
    end

    // Next-state decode and illegal opcode detection
    always_comb begin
        next_state_s = state_r;
        illegal_s    = 1'b0;
        case (state_r)
            S_FETCH: begin
                if (mem_ready) begin
                    next_state_s = S_DECODE;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state_s = S_MEMADR;
                    OP_RTYPE:     next_state_s = S_EXEC;
                    OP_BEQ:       next_state_s = S_BRANCH;
`ifdef CTRL_BNE_EN
                    OP_BNE:       next_state_s = S_BRANCH;
`endif
                    OP_ADDI:      next_state_s = S_ADDIEX;
                    OP_ORI:       next_state_s = S_ORIEX;
                    OP_J:         next_state_s = S_JUMP;
                    default: begin
                        next_state_s = S_FETCH;
                        illegal_s    = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                if (op == OP_LW) begin
                    next_state_s = S_MEMRD;
                end else begin
                    next_state_s = S_MEMWR;
                end
            end
            S_MEMRD: begin
                if (mem_ready) begin
                    next_state_s = S_MEMWB;
                end else begin
                    next_state_s = S_MEMRD;
                end
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    next_state_s = S_FETCH;
                end else begin
                    next_state_s = S_MEMWR;
                end
            end
            S_MEMWB:  next_state_s = S_FETCH;
            S_EXEC:   next_state_s = S_ALUWB;
            S_ALUWB:  next_state_s = S_FETCH;
            S_BRANCH: next_state_s = S_FETCH;
            S_ADDIEX: next_state_s = S_IMMWB;
            S_ORIEX:  next_state_s = S_IMMWB;
            S_IMMWB:  next_state_s = S_FETCH;
            S_JUMP:   next_state_s = S_FETCH;
            S_HALT:   next_state_s = S_HALT;
            default:  next_state_s = S_FETCH;
        endcase
    end

    // Per-state output decode; everything not named for a state stays 0
    always_comb begin
        mem_req_s    = 1'b0;
        memwrite_s   = 1'b0;
        pcen_s       = 1'b0;
        irwrite_s    = 1'b0;
        regwrite_s   = 1'b0;
        alusrca_s    = 1'b0;
        iord_s       = 1'b0;
        memtoreg_s   = 1'b0;
        regdst_s     = 1'b0;
        alusrcb_s    = 2'b00;
        pcsrc_s      = 2'b00;
        alucontrol_s = 3'b000;
        case (state_r)
            S_FETCH: begin
                mem_req_s    = 1'b1;
                alusrcb_s    = 2'b01;
                alucontrol_s = ALU_ADD;
                irwrite_s    = mem_ready;
                pcen_s       = mem_ready;
            end
            S_DECODE: begin
                alusrcb_s    = 2'b11;
                alucontrol_s = ALU_ADD;
            end
            S_MEMADR: begin
                alusrca_s    = 1'b1;
                alusrcb_s    = 2'b10;
                alucontrol_s = ALU_ADD;
            end
            S_MEMRD: begin
                mem_req_s = 1'b1;
                iord_s    = 1'b1;
            end
            S_MEMWB: begin
                regwrite_s = 1'b1;
                memtoreg_s = 1'b1;
            end
            S_MEMWR: begin
                mem_req_s  = 1'b1;
                memwrite_s = 1'b1;
                iord_s     = 1'b1;
            end
            S_EXEC: begin
                alusrca_s    = 1'b1;
                alucontrol_s = alu_from_funct(funct);
            end
            S_ALUWB: begin
                regwrite_s = 1'b1;
                regdst_s   = 1'b1;
            end
            S_BRANCH: begin
                alusrca_s    = 1'b1;
                alucontrol_s = ALU_SUB;
                pcsrc_s      = 2'b01;
                pcen_s       = branch_taken_s;
            end
            S_ADDIEX: begin
                alusrca_s    = 1'b1;
                alusrcb_s    = 2'b10;
                alucontrol_s = ALU_ADD;
            end
            S_ORIEX: begin
                alusrca_s    = 1'b1;
                alusrcb_s    = 2'b10;
                alucontrol_s = ALU_OR;
            end
            S_IMMWB: begin
                regwrite_s = 1'b1;
            end
            S_JUMP: begin
                pcsrc_s = 2'b10;
                pcen_s  = 1'b1;
            end
            S_HALT: begin
                mem_req_s = 1'b0;
            end
            default: begin
                mem_req_s = 1'b0;
            end
        endcase
    end

    // Wait-cycle detection; the counter saturates so a disabled timeout cannot wrap
    always_comb begin
        wait_s = mem_req_s & ~mem_ready;
        if (wait_cnt_r == CNT_MAX) begin
            cnt_inc_s = wait_cnt_r;
        end else begin
            cnt_inc_s = wait_cnt_r + CNT_ONE;
        end
        // Fault on the TIMEOUT_CYCLES-th consecutive wait; a ready in that cycle is not a wait
        if ((TIMEOUT_CYCLES != 0) && wait_s && (cnt_inc_s == TIMEOUT_L)) begin
            timeout_hit_s = 1'b1;
        end else begin
            timeout_hit_s = 1'b0;
        end
    end

    // State register, wait counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r       <= S_FETCH;
            wait_cnt_r    <= CNT_ZERO;
            mem_timeout_r <= 1'b0;
        end else if (timeout_hit_s) begin
            state_r       <= S_HALT;
            wait_cnt_r    <= CNT_ZERO;
            mem_timeout_r <= 1'b1;
        end else begin
            state_r <= next_state_s;
            // Waits never change state, so any non-wait cycle clears the count
            if (wait_s) begin
                wait_cnt_r <= cnt_inc_s;
            end else begin
                wait_cnt_r <= CNT_ZERO;
            end
        end
    end

    // Port drive: strobes are held low while reset is asserted
    always_comb begin
        mem_req     = mem_req_s & reset;
        memwrite    = memwrite_s & reset;
        pcen        = pcen_s & reset;
        irwrite     = irwrite_s & reset;
        regwrite    = regwrite_s & reset;
        illegal_op  = illegal_s & reset;
        alusrca     = alusrca_s;
        iord        = iord_s;
        memtoreg    = memtoreg_s;
        regdst      = regdst_s;
        alusrcb     = alusrcb_s;
        pcsrc       = pcsrc_s;
        alucontrol  = alucontrol_s;
        mem_timeout = mem_timeout_r;
        state       = state_r;
    end

endmodule

// File: tb/tb_mc_controller.sv
// ============================================================================
// tb_mc_controller
// Directed testbench for mc_controller with hand-computed expectations.
// Inputs change 1 time unit after a rising edge. Outputs are sampled 2 time
// units after the edge, once the combinational decode has settled.
// ============================================================================
module tb_mc_controller;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       memwrite;
    logic       pcen;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       illegal_op;
    logic       mem_timeout;
    logic [3:0] state;

    int n_cmp;
    int n_err;

    mc_controller #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .funct       (funct),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .memwrite    (memwrite),
        .pcen        (pcen),
        .irwrite     (irwrite),
        .regwrite    (regwrite),
        .alusrca     (alusrca),
        .iord        (iord),
        .memtoreg    (memtoreg),
        .regdst      (regdst),
        .alusrcb     (alusrcb),
        .pcsrc       (pcsrc),
        .alucontrol  (alucontrol),
        .illegal_op  (illegal_op),
        .mem_timeout (mem_timeout),
        .state       (state)
    );

    // 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock: lands 1 unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change
    task automatic settle();
        #1;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b0;
        op        = 6'b000000;
        funct     = 6'b100010;
        zero      = 1'b0;
        mem_ready = 1'b1;

        // ---- reset held low for 2 cycles ----
        step();
        step();
        settle();
        check_eq("rst_state", state, 32'd0);
        check_eq("rst_timeout", mem_timeout, 32'd0);
        check_eq("rst_mem_req", mem_req, 32'd0);
        check_eq("rst_pcen", pcen, 32'd0);
        check_eq("rst_irwrite", irwrite, 32'd0);

        // ---- R-type sub: 0,1,6,7,0 ----
        reset = 1'b1;
        settle();
        check_eq("r_fetch_state", state, 32'd0);
        check_eq("r_fetch_memreq", mem_req, 32'd1);
        check_eq("r_fetch_irwrite", irwrite, 32'd1);
        check_eq("r_fetch_pcen", pcen, 32'd1);
        check_eq("r_fetch_srcb", alusrcb, 32'd1);
        check_eq("r_fetch_alu", alucontrol, 32'b010);
        step(); settle();
        check_eq("r_decode_state", state, 32'd1);
        check_eq("r_decode_srcb", alusrcb, 32'b11);
        step(); settle();
        check_eq("r_exec_state", state, 32'd6);
        check_eq("r_exec_alu", alucontrol, 32'b110);
        check_eq("r_exec_srca", alusrca, 32'd1);
        check_eq("r_exec_srcb", alusrcb, 32'd0);
        step(); settle();
        check_eq("r_aluwb_state", state, 32'd7);
        check_eq("r_aluwb_regwrite", regwrite, 32'd1);
        check_eq("r_aluwb_regdst", regdst, 32'd1);
        check_eq("r_aluwb_memtoreg", memtoreg, 32'd0);
        step(); settle();
        check_eq("r_back_fetch", state, 32'd0);

        // ---- R-type slt funct decode ----
        funct = 6'b101010;
        step(); step(); settle();
        check_eq("slt_exec_alu", alucontrol, 32'b111);
        step(); step(); settle();

        // ---- lw with 3 wait states in MEMRD: 8 cycles total ----
        begin
            int cycles;
            cycles = 0;
            op = 6'b100011;
            settle();
            step(); cycles++;
            step(); cycles++;
            settle();
            check_eq("lw_memadr_state", state, 32'd2);
            check_eq("lw_memadr_srcb", alusrcb, 32'b10);
            step(); cycles++;
            mem_ready = 1'b0;
            for (int i = 0; i < 3; i++) begin
                settle();
                check_eq("lw_memrd_wait_state", state, 32'd3);
                check_eq("lw_memrd_wait_iord", iord, 32'd1);
                step(); cycles++;
            end
            mem_ready = 1'b1;
            settle();
            check_eq("lw_memrd_last_state", state, 32'd3);
            check_eq("lw_memrd_last_iord", iord, 32'd1);
            step(); cycles++;
            settle();
            check_eq("lw_memwb_state", state, 32'd4);
            check_eq("lw_memwb_regwrite", regwrite, 32'd1);
            check_eq("lw_memwb_memtoreg", memtoreg, 32'd1);
            check_eq("lw_memwb_regdst", regdst, 32'd0);
            step(); cycles++;
            settle();
            check_eq("lw_back_fetch", state, 32'd0);
            check_eq("lw_cycles", cycles, 32'd8);
        end

        // ---- beq taken then not taken ----
        op   = 6'b000100;
        zero = 1'b1;
        step(); step(); settle();
        check_eq("beq_t_state", state, 32'd8);
        check_eq("beq_t_pcen", pcen, 32'd1);
        check_eq("beq_t_pcsrc", pcsrc, 32'b01);
        check_eq("beq_t_alu", alucontrol, 32'b110);
        step();
        zero = 1'b0;
        step(); step(); settle();
        check_eq("beq_nt_state", state, 32'd8);
        check_eq("beq_nt_pcen", pcen, 32'd0);
        step();

        // ---- bne: branch when enabled, illegal otherwise ----
        op   = 6'b000101;
        zero = 1'b0;
        step(); settle();
`ifdef CTRL_BNE_EN
        check_eq("bne_decode_illegal", illegal_op, 32'd0);
        step(); settle();
        check_eq("bne_state", state, 32'd8);
        check_eq("bne_pcen", pcen, 32'd1);
        step();
`else
        check_eq("bne_decode_illegal", illegal_op, 32'd1);
        step(); settle();
        check_eq("bne_back_fetch", state, 32'd0);
`endif

        // ---- illegal opcode ----
        op = 6'b111111;
        step(); settle();
        check_eq("ill_decode_state", state, 32'd1);
        check_eq("ill_pulse", illegal_op, 32'd1);
        check_eq("ill_decode_regwrite", regwrite, 32'd0);
        step(); settle();
        check_eq("ill_next_state", state, 32'd0);
        check_eq("ill_pulse_end", illegal_op, 32'd0);
        check_eq("ill_fetch_regwrite", regwrite, 32'd0);

        // ---- ori and jump ----
        op = 6'b001101;
        step(); step(); settle();
        check_eq("ori_state", state, 32'd12);
        check_eq("ori_alu", alucontrol, 32'b001);
        check_eq("ori_srcb", alusrcb, 32'b10);
        step(); settle();
        check_eq("ori_immwb_state", state, 32'd10);
        check_eq("ori_immwb_regwrite", regwrite, 32'd1);
        step();
        op = 6'b000010;
        step(); step(); settle();
        check_eq("j_state", state, 32'd11);
        check_eq("j_pcen", pcen, 32'd1);
        check_eq("j_pcsrc", pcsrc, 32'b10);
        step();

        // ---- sw, reset asserted mid-MEMWR ----
        op = 6'b101011;
        step(); step(); step();
        mem_ready = 1'b0;
        settle();
        check_eq("sw_memwr_state", state, 32'd5);
        check_eq("sw_memwr_memwrite", memwrite, 32'd1);
        reset = 1'b0;
        settle();
        check_eq("sw_rst_memwrite", memwrite, 32'd0);
        check_eq("sw_rst_memreq", mem_req, 32'd0);
        step(); settle();
        check_eq("sw_rst_state", state, 32'd0);
        reset = 1'b1;

        // ---- 15 waits then ready on the 16th: no fault ----
        op = 6'b000010;
        mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
        end
        mem_ready = 1'b1;
        settle();
        check_eq("edge_fetch_state", state, 32'd0);
        step(); settle();
        check_eq("edge_no_timeout", mem_timeout, 32'd0);
        check_eq("edge_decode_state", state, 32'd1);
        step(); step();

        // ---- 16 waits in FETCH: timeout into HALT ----
        mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
        end
        settle();
        check_eq("to_pre_state", state, 32'd0);
        check_eq("to_pre_flag", mem_timeout, 32'd0);
        step(); settle();
        check_eq("to_state", state, 32'd13);
        check_eq("to_flag", mem_timeout, 32'd1);
        check_eq("to_memreq", mem_req, 32'd0);
        mem_ready = 1'b1;
        step(); step(); settle();
        check_eq("halt_hold_state", state, 32'd13);
        check_eq("halt_pcen", pcen, 32'd0);
        check_eq("halt_irwrite", irwrite, 32'd0);
        check_eq("halt_flag_sticky", mem_timeout, 32'd1);
        reset = 1'b0;
        step(); settle();
        check_eq("halt_rst_state", state, 32'd0);
        check_eq("halt_rst_flag", mem_timeout, 32'd0);
        reset = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
